// File: rtl/mattrans_pkg.sv
// Shared types and sizing helpers for the streaming matrix transposer.
package mattrans_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int BIN_POS_DEF     = 8;
  localparam int MATRIX_SIZE_DEF = 4;

  localparam int ROW_W = MATRIX_SIZE_DEF * DATA_WIDTH_DEF;
  localparam int PTR_W = $clog2(MATRIX_SIZE_DEF);

  function automatic int row_width(input int n, input int dw);
    return n * dw;
  endfunction

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mattrans_bank.sv
// One N x N storage bank: row write port, row read port with transpose select.
module mattrans_bank
  import mattrans_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
  localparam int RW = row_width(MATRIX_SIZE, DATA_WIDTH),
  localparam int PW = ptr_width(MATRIX_SIZE)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_row,
  input  logic [RW-1:0] wr_data,
  input  logic [PW-1:0] rd_row,
  input  logic          rd_trans,
  output logic [RW-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r  [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] view_s [MATRIX_SIZE][MATRIX_SIZE];

  // Row write into storage (contents deliberately not reset)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        mem_r[wr_row][j] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Storage as it will look after this edge, so the caller can register a row landing now
  always_comb begin
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        if (wr_en && (wr_row == PW'(i))) begin
          view_s[i][j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          view_s[i][j] = mem_r[i][j];
        end
      end
    end
  end

  // Row read: a stored row, or a stored column when transposing
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < MATRIX_SIZE; j++) begin
      if (rd_trans) begin
        rd_data[j*DATA_WIDTH +: DATA_WIDTH] = view_s[j][rd_row];
      end else begin
        rd_data[j*DATA_WIDTH +: DATA_WIDTH] = view_s[rd_row][j];
      end
    end
  end

endmodule

// File: rtl/mattrans_stream.sv
// Streaming double-buffered transposer: rows in, transposed (or unchanged) rows out,
// two ping-pong banks so one matrix loads while the previous one drains.
module mattrans_stream
  import mattrans_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int BIN_POS     = BIN_POS_DEF,
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] in_row,
  input  logic                              in_trans,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] out_row,
  output logic                              out_last
);

  localparam int RW = row_width(MATRIX_SIZE, DATA_WIDTH);
  localparam int PW = ptr_width(MATRIX_SIZE);
  localparam logic [PW-1:0] LAST_ROW = PW'(MATRIX_SIZE - 1);

  if (MATRIX_SIZE < 2) begin : g_size_check
    $error("mattrans_stream: MATRIX_SIZE must be at least 2");
  end
  if ((BIN_POS < 0) || (BIN_POS > DATA_WIDTH)) begin : g_bin_pos_check
    $error("mattrans_stream: BIN_POS must lie within DATA_WIDTH");
  end

  bank_state_t   st_r     [2];
  bank_state_t   st_nxt_s [2];
  logic [1:0]    mode_r;
  logic [1:0]    mode_nxt_s;
  logic          wr_bank_r;
  logic          wr_bank_nxt_s;
  logic          rd_bank_r;
  logic          rd_bank_nxt_s;
  logic [PW-1:0] wr_row_r;
  logic [PW-1:0] wr_row_nxt_s;
  logic [PW-1:0] rd_row_r;
  logic [PW-1:0] rd_row_nxt_s;

  logic          in_fire_s;
  logic          out_fire_s;
  logic          in_ready_nxt_s;
  logic          out_valid_nxt_s;
  logic          out_last_nxt_s;
  logic [RW-1:0] out_row_nxt_s;
  logic [1:0]    we_s;
  logic [RW-1:0] rd_data_s [2];

  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;

  // The read port looks at next-cycle pointers so out_row can be registered
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we_s[b] = in_fire_s && (wr_bank_r == 1'(b));

    mattrans_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MATRIX_SIZE (MATRIX_SIZE)
    ) u_bank (
      .clk      (clk),
      .wr_en    (we_s[b]),
      .wr_row   (wr_row_r),
      .wr_data  (in_row),
      .rd_row   (rd_row_nxt_s),
      .rd_trans (mode_nxt_s[b]),
      .rd_data  (rd_data_s[b])
    );
  end

  // Bank state and pointer advance; write and read never target the same bank
  always_comb begin
    st_nxt_s      = st_r;
    mode_nxt_s    = mode_r;
    wr_bank_nxt_s = wr_bank_r;
    rd_bank_nxt_s = rd_bank_r;
    wr_row_nxt_s  = wr_row_r;
    rd_row_nxt_s  = rd_row_r;
    if (in_fire_s) begin
      mode_nxt_s[wr_bank_r] = (wr_row_r == '0) ? in_trans : mode_r[wr_bank_r];
      if (wr_row_r == LAST_ROW) begin
        st_nxt_s[wr_bank_r] = FULL;
        wr_row_nxt_s        = '0;
        wr_bank_nxt_s       = ~wr_bank_r;
      end else begin
        st_nxt_s[wr_bank_r] = FILLING;
        wr_row_nxt_s        = wr_row_r + PW'(1);
      end
    end else begin
      wr_row_nxt_s = wr_row_r;
    end
    if (out_fire_s) begin
      if (rd_row_r == LAST_ROW) begin
        st_nxt_s[rd_bank_r] = EMPTY;
        rd_row_nxt_s        = '0;
        rd_bank_nxt_s       = ~rd_bank_r;
      end else begin
        rd_row_nxt_s = rd_row_r + PW'(1);
      end
    end else begin
      rd_row_nxt_s = rd_row_r;
    end
  end

  // Output values for the next cycle, derived from next-cycle state only
  always_comb begin
    in_ready_nxt_s  = (st_nxt_s[wr_bank_nxt_s] != FULL);
    out_valid_nxt_s = (st_nxt_s[rd_bank_nxt_s] == FULL);
    out_last_nxt_s  = out_valid_nxt_s && (rd_row_nxt_s == LAST_ROW);
    if (!out_valid_nxt_s) begin
      out_row_nxt_s = '0;
    end else if (rd_bank_nxt_s) begin
      out_row_nxt_s = rd_data_s[1];
    end else begin
      out_row_nxt_s = rd_data_s[0];
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r[0]   <= EMPTY;
      st_r[1]   <= EMPTY;
      mode_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_row_r  <= '0;
      rd_row_r  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
    end else begin
      st_r      <= st_nxt_s;
      mode_r    <= mode_nxt_s;
      wr_bank_r <= wr_bank_nxt_s;
      rd_bank_r <= rd_bank_nxt_s;
      wr_row_r  <= wr_row_nxt_s;
      rd_row_r  <= rd_row_nxt_s;
      in_ready  <= in_ready_nxt_s;
      out_valid <= out_valid_nxt_s;
      out_last  <= out_last_nxt_s;
      out_row   <= out_row_nxt_s;
    end
  end

endmodule

// File: doc/mattrans_stream.md
Name: mattrans_stream

Overview:
- Streaming, double-buffered successor to the combinational square-matrix transposer, for fixed-point matrices of MATRIX_SIZE x MATRIX_SIZE elements of DATA_WIDTH bits.
- Accepts one matrix row per cycle over a valid/ready handshake and emits one transposed row (an input column) per cycle over a second valid/ready handshake.
- Two ping-pong banks let one matrix load while the previous one drains. A per-matrix mode selects transpose or pass-through.
- Sits between matrix producers (navigation filter stages) and consumers that need column order, without an N^2-wide combinational bus.

Parameters:
- DATA_WIDTH, 16, bits per element (signed fixed-point).
- BIN_POS, 8, binary point position. No arithmetic is done on it; it is carried only for interface consistency with the other matrix blocks.
- MATRIX_SIZE, 4, N: the matrix is N x N. Legal range is N >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_row is valid.
- in_ready  out  1  block can accept a row this cycle.
- in_row  in  N*DATA_WIDTH  one input row; column j is at [j*DATA_WIDTH +: DATA_WIDTH].
- in_trans  in  1  mode for the matrix: 1 = transpose, 0 = pass-through. Sampled only with row 0.
- out_valid  out  1  out_row is valid.
- out_ready  in  1  consumer accepts out_row.
- out_row  out  N*DATA_WIDTH  one output row, same packing as in_row.
- out_last  out  1  out_row is row N-1 of the current matrix.

Behaviour:
- Bank state, per bank: EMPTY -> FILLING -> FULL -> EMPTY.
- Pointers:
  - wr_bank and wr_row (0..N-1) track the input side.
  - rd_bank and rd_row (0..N-1) track the output side.
- Reset (async, rst_n low):
  - Both banks EMPTY; wr_bank = rd_bank = 0; wr_row = rd_row = 0; stored modes = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_last = 0, out_row = 0.
  - Storage array is not reset.
- in_ready:
  - Is 1 when bank[wr_bank] is EMPTY or FILLING.
  - Is purely state-derived; it must not depend on in_valid.
- Input transfer (in_valid && in_ready at a rising edge):
  - Store in_row at mem[wr_bank][wr_row][*].
  - If wr_row == 0, latch in_trans into mode[wr_bank] and set the bank to FILLING.
  - wr_row increments.
  - When wr_row == N-1: the bank becomes FULL, wr_row wraps to 0 and wr_bank toggles.
- out_valid:
  - Is 1 when bank[rd_bank] is FULL.
  - Latency: out_valid rises on the edge that accepts the last input row, so a FULL bank asserts out_valid in the following cycle.
- out_row element j:
  - mode = 1: mem[rd_bank][j][rd_row].
  - mode = 0: mem[rd_bank][rd_row][j].
  - Is 0 when out_valid = 0.
- out_last = out_valid && rd_row == N-1.
- Output transfer (out_valid && out_ready):
  - rd_row increments.
  - At N-1: the bank becomes EMPTY, rd_row wraps to 0 and rd_bank toggles.
- Stall rules:
  - While out_valid && !out_ready, out_row and out_last are held stable.
  - in_valid may drop mid-matrix; wr_row holds.
- Simultaneous events:
  - Writing one bank and reading the other in the same cycle is legal. This gives 1 row/cycle sustained throughput in each direction.
  - A bank never reads and writes in the same cycle (guaranteed by the state rules).
  - The cycle a bank goes EMPTY, it is writable on the next edge. There is no same-cycle bypass.
- Full condition: both banks FULL -> in_ready = 0 until one row-set drains.
- Reset mid-operation discards all partial and full matrices. The first accepted row after reset is row 0 of bank 0.
- in_trans on rows 1..N-1 is ignored.

Decomposition:
- Package mattrans_pkg holds:
  - the bank_state_t enum (EMPTY, FILLING, FULL);
  - the localparam ROW_W = N*DATA_WIDTH;
  - the pointer width $clog2(N).
- Sub-module mattrans_bank: N x N register storage for one bank, with a row write port and a row read port. Its read port has a transpose select.
- Top level instantiates two mattrans_bank instances plus the control FSM and pointers.

Test Plan (N=3, DATA_WIDTH=8, BIN_POS=4):
- Basic transpose:
  - Stimulus: reset, in_trans = 1, rows {10,20,30}, {40,50,60}, {70,80,90} hex.
  - Response: out rows {10,40,70}, {20,50,80}, {30,60,90}; out_last on the third; out_valid first asserted 1 cycle after the third input is accepted.
- Pass-through: same rows with in_trans = 0 -> identical rows out in order.
- Back-to-back: 4 matrices, out_ready = 1, in_valid = 1 -> in_ready never drops after the first matrix; 12 outputs in 12 consecutive cycles after the initial 3-cycle fill; per-matrix mode honoured (alternate 1/0).
- Backpressure:
  - out_ready = 0 while 2 matrices are loaded -> in_ready = 0 on the 7th row attempt.
  - out_row is stable across 5 stall cycles.
  - Releasing out_ready -> in_ready returns 1 the cycle after the first bank empties.
- Bubbles: random in_valid/out_ready gaps (seeded) -> output matches the golden transpose; in_trans changed on rows 1-2 has no effect.
- Reset mid-operation:
  - Assert rst_n = 0 after 2 rows of matrix A -> out_valid = 0 and in_ready = 1 immediately (async).
  - After release, a new matrix B is transposed correctly with no A data appearing.
